// File: rtl/ram_controller.sv
// ram_controller: single-beat CPU-to-async-SRAM initiator.
// Accepts read/write requests on a valid/ready handshake, sequences the
// active-low chip/output/write enables, drives or releases the shared data
// bus, and returns a one-cycle respValid pulse per completed access.
//
// Optional feature macro: RAM_CTRL_TURNAROUND_EN
//   When defined, a write that follows a completed read first spends one
//   BUS_TURN cycle with all strobes high and io released.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   reqValid/reqReady   request handshake (accept = reqValid && reqReady)
//   reqWrite            1 = write, 0 = read
//   reqAddress          request address, latched at accept
//   reqWriteData        write data, latched at accept
//   respValid           one-cycle completion pulse (reads and writes)
//   respData            last captured read data
//   address             SRAM address
//   notChipEnable       SRAM CE#, active low
//   notOutputEnable     SRAM OE#, active low
//   notWriteEnable      SRAM WE#, active low
//   io                  SRAM bidirectional data bus
module ram_controller #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned READ_WAIT   = 2,
  parameter int unsigned WRITE_PULSE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  input  logic                  reqWrite,
  input  logic [ADDR_WIDTH-1:0] reqAddress,
  input  logic [DATA_WIDTH-1:0] reqWriteData,
  output logic                  reqReady,
  output logic                  respValid,
  output logic [DATA_WIDTH-1:0] respData,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  notChipEnable,
  output logic                  notOutputEnable,
  output logic                  notWriteEnable,
  inout  wire  [DATA_WIDTH-1:0] io
);

  localparam int unsigned MAX_WAIT    = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
  localparam int unsigned COUNT_WIDTH = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RD_SETUP = 3'd1;
  localparam logic [2:0] RD_WAIT  = 3'd2;
  localparam logic [2:0] WR_SETUP = 3'd3;
  localparam logic [2:0] WR_PULSE = 3'd4;
  localparam logic [2:0] WR_HOLD  = 3'd5;
`ifdef RAM_CTRL_TURNAROUND_EN
  localparam logic [2:0] BUS_TURN = 3'd6;
`endif

  logic [2:0]             state;
  logic [2:0]             stateNext;
  logic [COUNT_WIDTH-1:0] waitCount;
  logic [COUNT_WIDTH-1:0] waitCountNext;
  logic [DATA_WIDTH-1:0]  writeData;
  logic [DATA_WIDTH-1:0]  writeDataNext;
  logic [ADDR_WIDTH-1:0]  addressNext;
  logic [DATA_WIDTH-1:0]  respDataNext;
  logic                   respValidNext;
  logic                   reqReadyNext;
  logic                   notChipEnableNext;
  logic                   notOutputEnableNext;
  logic                   notWriteEnableNext;
  logic                   driveEnable;
  logic                   driveEnableNext;
`ifdef RAM_CTRL_TURNAROUND_EN
  logic                   lastWasRead;
  logic                   lastWasReadNext;
`endif

  // Bus is driven only from registered enable/data, so no glitches reach the SRAM.
  assign io = driveEnable ? writeData : {DATA_WIDTH{1'bz}};

  // Next-state, counter and next-output logic.
  always_comb begin
    stateNext     = state;
    waitCountNext = waitCount;
    writeDataNext = writeData;
    addressNext   = address;
    respDataNext  = respData;
    respValidNext = 1'b0;
`ifdef RAM_CTRL_TURNAROUND_EN
    lastWasReadNext = lastWasRead;
`endif

    case (state)
      IDLE: begin
        if (reqValid && reqReady) begin
          addressNext   = reqAddress;
          writeDataNext = reqWriteData;
          if (reqWrite) begin
`ifdef RAM_CTRL_TURNAROUND_EN
            stateNext = lastWasRead ? BUS_TURN : WR_SETUP;
`else
            stateNext = WR_SETUP;
`endif
          end else begin
            stateNext = RD_SETUP;
          end
        end
      end
      RD_SETUP: begin
        stateNext     = RD_WAIT;
        waitCountNext = COUNT_WIDTH'(READ_WAIT - 1);
      end
      RD_WAIT: begin
        if (waitCount == '0) begin
          respDataNext  = io;
          respValidNext = 1'b1;
          stateNext     = IDLE;
`ifdef RAM_CTRL_TURNAROUND_EN
          lastWasReadNext = 1'b1;
`endif
        end else begin
          waitCountNext = waitCount - COUNT_WIDTH'(1);
        end
      end
      WR_SETUP: begin
        stateNext     = WR_PULSE;
        waitCountNext = COUNT_WIDTH'(WRITE_PULSE - 1);
      end
      WR_PULSE: begin
        if (waitCount == '0) begin
          stateNext = WR_HOLD;
        end else begin
          waitCountNext = waitCount - COUNT_WIDTH'(1);
        end
      end
      WR_HOLD: begin
        stateNext     = IDLE;
        respValidNext = 1'b1;
`ifdef RAM_CTRL_TURNAROUND_EN
        lastWasReadNext = 1'b0;
`endif
      end
`ifdef RAM_CTRL_TURNAROUND_EN
      BUS_TURN: begin
        stateNext = WR_SETUP;
      end
`endif
      default: begin
        stateNext = IDLE;
      end
    endcase

    // Strobes are decoded from the upcoming state and registered with it.
    notChipEnableNext   = !((stateNext == RD_SETUP) || (stateNext == RD_WAIT) ||
                            (stateNext == WR_SETUP) || (stateNext == WR_PULSE) ||
                            (stateNext == WR_HOLD));
    notOutputEnableNext = (stateNext != RD_WAIT);
    notWriteEnableNext  = (stateNext != WR_PULSE);
    driveEnableNext     = (stateNext == WR_SETUP) || (stateNext == WR_PULSE) ||
                          (stateNext == WR_HOLD);
    reqReadyNext        = (stateNext == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      waitCount       <= '0;
      writeData       <= '0;
      address         <= '0;
      respData        <= '0;
      respValid       <= 1'b0;
      reqReady        <= 1'b1;
      notChipEnable   <= 1'b1;
      notOutputEnable <= 1'b1;
      notWriteEnable  <= 1'b1;
      driveEnable     <= 1'b0;
`ifdef RAM_CTRL_TURNAROUND_EN
      lastWasRead     <= 1'b0;
`endif
    end else begin
      state           <= stateNext;
      waitCount       <= waitCountNext;
      writeData       <= writeDataNext;
      address         <= addressNext;
      respData        <= respDataNext;
      respValid       <= respValidNext;
      reqReady        <= reqReadyNext;
      notChipEnable   <= notChipEnableNext;
      notOutputEnable <= notOutputEnableNext;
      notWriteEnable  <= notWriteEnableNext;
      driveEnable     <= driveEnableNext;
`ifdef RAM_CTRL_TURNAROUND_EN
      lastWasRead     <= lastWasReadNext;
`endif
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Testbench for ram_controller. Two instances are built: configuration 0 with
// READ_WAIT = WRITE_PULSE = 2 and configuration 1 with READ_WAIT =
// WRITE_PULSE = 1. Each has its own behavioural SRAM on a pulled-up bus, so a
// released bus reads back as 0xFF. sel picks which instance receives requests.
module tb_ram_controller;

`ifdef RAM_CTRL_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif
  localparam int NCFG = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        preload;
  logic        sel;
  logic        reqValid;
  logic        reqWrite;
  logic [11:0] reqAddress;
  logic [7:0]  reqWriteData;

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input int cfg, input int a);
    return 8'((a * 37 + cfg * 11) ^ (a >> 4));
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : gCfg
    tri1 [7:0]   io;
    logic [7:0]  mem [4096];
    logic        reqReady, respValid, nCe, nOe, nWe;
    logic [7:0]  respData;
    logic [11:0] addr;

    ram_controller #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (8),
      .READ_WAIT  (g == 0 ? 2 : 1),
      .WRITE_PULSE(g == 0 ? 2 : 1)
    ) dut (
      .clk            (clk),
      .reset          (reset),
      .reqValid       (reqValid && (sel == 1'(g))),
      .reqWrite       (reqWrite),
      .reqAddress     (reqAddress),
      .reqWriteData   (reqWriteData),
      .reqReady       (reqReady),
      .respValid      (respValid),
      .respData       (respData),
      .address        (addr),
      .notChipEnable  (nCe),
      .notOutputEnable(nOe),
      .notWriteEnable (nWe),
      .io             (io)
    );

    // Asynchronous SRAM: drives the bus while CE and OE are low, WE high.
    assign io = (!nCe && !nOe && nWe) ? mem[addr] : 8'hzz;

    always @(posedge clk) begin
      if (preload) begin
        for (int i = 0; i < 4096; i++) mem[i] <= initVal(g, i);
      end else if (!nCe && !nWe) begin
        mem[addr] <= io;
      end
    end
  end

  logic        curReqReady, curRespValid, curNCe, curNOe, curNWe;
  logic [7:0]  curRespData, curIo;
  logic [11:0] curAddress;
  assign curReqReady  = sel ? gCfg[1].reqReady  : gCfg[0].reqReady;
  assign curRespValid = sel ? gCfg[1].respValid : gCfg[0].respValid;
  assign curRespData  = sel ? gCfg[1].respData  : gCfg[0].respData;
  assign curAddress   = sel ? gCfg[1].addr      : gCfg[0].addr;
  assign curNCe       = sel ? gCfg[1].nCe       : gCfg[0].nCe;
  assign curNOe       = sel ? gCfg[1].nOe       : gCfg[0].nOe;
  assign curNWe       = sel ? gCfg[1].nWe       : gCfg[0].nWe;
  assign curIo        = sel ? gCfg[1].io        : gCfg[0].io;

  int vectors;
  int miscompares;

  // Reference model: memory image, last read data and last completed op kind.
  logic [7:0] modelMem  [NCFG][4096];
  logic [7:0] modelResp [NCFG];
  logic       modelLastRead [NCFG];

  function automatic int rwOf(input logic s);
    return s ? 1 : 2;
  endfunction

  function automatic int wpOf(input logic s);
    return s ? 1 : 2;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s (cfg %0d): got 0x%0h, expected 0x%0h", name, sel, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCFG; c++) begin
      modelResp[c]     = 8'h00;
      modelLastRead[c] = 1'b0;
    end
  endtask

  task automatic modelUpdate(input logic w, input logic [11:0] a, input logic [7:0] d);
    if (w) begin
      modelMem[sel][a]   = d;
      modelLastRead[sel] = 1'b0;
    end else begin
      modelResp[sel]     = modelMem[sel][a];
      modelLastRead[sel] = 1'b1;
    end
  endtask

  // Issue one request at a negedge and follow it to its completion pulse.
  // Returns at the negedge inside the respValid cycle.
  task automatic runOp(input logic w, input logic [11:0] a, input logic [7:0] d,
                       input int lat, input logic [7:0] expData, input string tag);
    int ceLow, oeLow, weLow, ioBad, addrBad, busyBad, rw, wp;
    ceLow = 0; oeLow = 0; weLow = 0; ioBad = 0; addrBad = 0; busyBad = 0;
    rw = rwOf(sel);
    wp = wpOf(sel);
    check({tag, " reqReady at issue"}, 32'(curReqReady), 1);
    reqValid = 1'b1; reqWrite = w; reqAddress = a; reqWriteData = d;
    @(posedge clk);
    @(negedge clk);
    for (int n = 0; n < lat; n++) begin
      if (curRespValid || curReqReady) busyBad++;
      if (curAddress != a) addrBad++;
      if (!curNCe) ceLow++;
      if (!curNOe) oeLow++;
      if (!curNWe) weLow++;
      if (w && !curNCe && curIo != d) ioBad++;
      if (w && curNCe && curIo != 8'hFF) ioBad++;
      if (!w && curNOe && curIo != 8'hFF) ioBad++;
      // Busy-time request noise must be ignored.
      reqValid     = 1'($urandom);
      reqWrite     = 1'($urandom);
      reqAddress   = 12'($urandom);
      reqWriteData = 8'($urandom);
      @(negedge clk);
    end
    reqValid = 1'b0;
    check({tag, " respValid at latency"}, 32'(curRespValid), 1);
    check({tag, " busy-window flags"}, busyBad, 0);
    check({tag, " respData"}, 32'(curRespData), 32'(expData));
    check({tag, " CE low cycles"}, ceLow, w ? 2 + wp : 1 + rw);
    check({tag, " WE low cycles"}, weLow, w ? wp : 0);
    check({tag, " OE low cycles"}, oeLow, w ? 0 : rw);
    check({tag, " io bus"}, ioBad, 0);
    check({tag, " address stable"}, addrBad, 0);
    check({tag, " idle strobes"}, 32'({curNCe, curNOe, curNWe}), 32'h7);
    check({tag, " io released"}, 32'(curIo), 32'hFF);
  endtask

  task automatic modelOp(input logic w, input logic [11:0] a, input logic [7:0] d);
    int lat;
    logic [7:0] expData;
    if (w) begin
      lat = 2 + wpOf(sel) + ((TURN == 1 && modelLastRead[sel]) ? 1 : 0);
      expData = modelResp[sel];
    end else begin
      lat = 1 + rwOf(sel);
      expData = modelMem[sel][a];
    end
    runOp(w, a, d, lat, expData, w ? "rand write" : "rand read");
    modelUpdate(w, a, d);
  endtask

  typedef struct {
    logic        cfg;
    logic        w;
    logic [11:0] a;
    logic [7:0]  d;
    int          lat;
    logic [7:0]  rdata;
  } vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [10];
    int   weSeen;
    int   strayResp;

    vectors = 0; miscompares = 0;
    reqValid = 1'b0; reqWrite = 1'b0; reqAddress = '0; reqWriteData = '0;
    sel = 1'b0; reset = 1'b1; preload = 1'b1;
    for (int c = 0; c < NCFG; c++)
      for (int i = 0; i < 4096; i++) modelMem[c][i] = initVal(c, i);
    modelReset();

    // Reset held for two edges, then released.
    @(negedge clk); preload = 1'b0;
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      sel = 1'(c);
      check("reset strobes", 32'({curNCe, curNOe, curNWe}), 32'h7);
      check("reset reqReady", 32'(curReqReady), 1);
      check("reset respValid", 32'(curRespValid), 0);
      check("reset respData", 32'(curRespData), 0);
      check("reset address", 32'(curAddress), 0);
      check("reset io", 32'(curIo), 32'hFF);
    end

    // Directed table; consecutive entries run back-to-back.
    tbl[0] = '{1'b0, 1'b1, 12'h000, 8'hC3, 4,        8'h00};
    tbl[1] = '{1'b0, 1'b1, 12'h123, 8'hA5, 4,        8'h00};
    tbl[2] = '{1'b0, 1'b0, 12'h123, 8'h00, 3,        8'hA5};
    tbl[3] = '{1'b0, 1'b1, 12'hFFF, 8'h3C, 4 + TURN, 8'hA5};
    tbl[4] = '{1'b0, 1'b0, 12'h000, 8'h00, 3,        8'hC3};
    tbl[5] = '{1'b0, 1'b0, 12'hFFF, 8'h00, 3,        8'h3C};
    tbl[6] = '{1'b1, 1'b1, 12'h7FF, 8'h11, 3,        8'h00};
    tbl[7] = '{1'b1, 1'b0, 12'h7FF, 8'h00, 2,        8'h11};
    tbl[8] = '{1'b1, 1'b1, 12'h800, 8'h22, 3 + TURN, 8'h11};
    tbl[9] = '{1'b1, 1'b0, 12'h800, 8'h00, 2,        8'h22};
    for (int i = 0; i < 10; i++) begin
      sel = tbl[i].cfg;
      runOp(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].rdata,
            tbl[i].w ? "table write" : "table read");
      modelUpdate(tbl[i].w, tbl[i].a, tbl[i].d);
    end

    // Reset asserted while WE is low aborts the write without a response.
    sel = 1'b0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddress = 12'h055; reqWriteData = 8'h77;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    weSeen = 0;
    for (int n = 0; n < 4 && weSeen == 0; n++) begin
      if (!curNWe) weSeen = 1;
      else @(negedge clk);
    end
    check("abort: WE pulse reached", weSeen, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort: strobes", 32'({curNCe, curNOe, curNWe}), 32'h7);
    check("abort: io", 32'(curIo), 32'hFF);
    check("abort: respValid", 32'(curRespValid), 0);
    check("abort: reqReady", 32'(curReqReady), 1);
    reset = 1'b0;
    modelReset();
    // WE was low through one edge, so the SRAM cell already took the data.
    modelMem[0][12'h055] = 8'h77;
    strayResp = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (curRespValid) strayResp++;
    end
    check("abort: no late respValid", strayResp, 0);
    modelOp(1'b0, 12'h055, 8'h00);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [11:0] a;
      int          gap;
      sel = 1'($urandom);
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) @(negedge clk);
      w = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 12'h000;
        1:       a = 12'hFFF;
        default: a = 12'($urandom);
      endcase
      modelOp(w, a, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
